// File: rtl/eu_seq_ctrl_if.sv
// rtl/eu_seq_ctrl_if.sv - fetch handshake and datapath control bundle of the execution-unit sequencer
interface eu_seq_ctrl_if;
  logic        instr_vld_i;
  logic [15:0] instr_i;
  logic        instr_rdy_o;
  logic        illegal_o;
  logic        data_mem_rd_enb_o;
  logic        data_mem_wr_enb_o;
  logic        wr_data_sel_o;
  logic        rf_wr_enb_o;
  logic        r0_const_sel_o;
  logic        r1_const_sel_o;
  logic        cf_sel_o;
  logic        cmp_flag_sel_o;
  logic [1:0]  alu_sel_0_o;
  logic        alu_sel_1_o;
  logic        inv_sel_o;
  logic        shftr_sel_o;
  logic        shftl_sel_o;
  logic [1:0]  r0_sel_o;
  logic [1:0]  r1_sel_o;
  logic [15:0] retired_cnt_o;

  modport slave (
    input  instr_vld_i, instr_i,
    output instr_rdy_o, illegal_o, data_mem_rd_enb_o, data_mem_wr_enb_o, wr_data_sel_o,
           rf_wr_enb_o, r0_const_sel_o, r1_const_sel_o, cf_sel_o, cmp_flag_sel_o,
           alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o,
           r0_sel_o, r1_sel_o, retired_cnt_o
  );

  modport master (
    output instr_vld_i, instr_i,
    input  instr_rdy_o, illegal_o, data_mem_rd_enb_o, data_mem_wr_enb_o, wr_data_sel_o,
           rf_wr_enb_o, r0_const_sel_o, r1_const_sel_o, cf_sel_o, cmp_flag_sel_o,
           alu_sel_0_o, alu_sel_1_o, inv_sel_o, shftr_sel_o, shftl_sel_o,
           r0_sel_o, r1_sel_o, retired_cnt_o
  );
endinterface

// File: rtl/eu_seq_ctrl.sv
// rtl/eu_seq_ctrl.sv - execution-unit sequencer: one instruction at a time, registered datapath controls
// Optional retired-instruction counter enabled by defining EU_SEQ_RETIRE_CNT_EN.
module eu_seq_ctrl #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  eu_seq_ctrl_if.slave bus
);

  localparam logic [3:0] OP_LD = 4'h9;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_WAIT, S_WB} state_t;

  typedef struct packed {
    logic       illegal;
    logic       rd_enb;
    logic       wr_enb;
    logic       wr_data_sel;
    logic       rf_wr_enb;
    logic       r0_const_sel;
    logic       r1_const_sel;
    logic       cf_sel;
    logic       cmp_flag_sel;
    logic [1:0] alu_sel_0;
    logic       alu_sel_1;
    logic       inv_sel;
    logic       shftr_sel;
    logic       shftl_sel;
    logic [1:0] r0_sel;
    logic [1:0] r1_sel;
  } ctrl_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_instr, w_instr_nxt;
  logic [2:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        r_rdy, w_rdy_nxt;
  ctrl_t       r_ctrl, w_ctrl_nxt;
  logic        w_accept;
  logic        w_unused_imm;

  assign w_accept     = (r_state == S_IDLE) && r_rdy && bus.instr_vld_i;
  assign w_unused_imm = ^r_instr[7:0];

  // Controls for the EXEC cycle are decoded straight from the accepted word so they register on the accept edge.
  function automatic ctrl_t decode(input logic [15:0] ins);
    ctrl_t c;
    c        = '0;
    c.r0_sel = ins[11:10];
    c.r1_sel = ins[9:8];
    case (ins[15:12])
      4'h1, 4'h2, 4'h3, 4'h4: begin
        c.alu_sel_0 = 2'(ins[15:12] - 4'h1);
        c.rf_wr_enb = 1'b1;
      end
      4'h5: begin c.alu_sel_1 = 1'b1; c.inv_sel   = 1'b1; c.rf_wr_enb = 1'b1; end
      4'h6: begin c.alu_sel_1 = 1'b1; c.shftr_sel = 1'b1; c.rf_wr_enb = 1'b1; end
      4'h7: begin c.alu_sel_1 = 1'b1; c.shftl_sel = 1'b1; c.rf_wr_enb = 1'b1; end
      4'h8: begin c.r0_const_sel = 1'b1; c.rf_wr_enb = 1'b1; end
      4'h9: c.rd_enb = 1'b1;
      4'hA: c.wr_enb = 1'b1;
      4'hB: c.cmp_flag_sel = 1'b1;
      4'hC: begin c.cmp_flag_sel = 1'b1; c.cf_sel = 1'b1; end
      4'hD, 4'hE, 4'hF: c.illegal = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_state_nxt    = r_state;
    w_instr_nxt    = r_instr;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ctrl_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_EXEC;
          w_instr_nxt = bus.instr_i;
          w_ctrl_nxt  = decode(bus.instr_i);
        end
      end
      S_EXEC: begin
        if (r_instr[15:12] == OP_LD) begin
          w_ctrl_nxt.r0_sel = r_instr[11:10];
          w_ctrl_nxt.r1_sel = r_instr[9:8];
          if (MEM_RD_LAT > 1) begin
            w_state_nxt    = S_MEM_WAIT;
            w_wait_cnt_nxt = 3'(MEM_RD_LAT - 1);
          end else begin
            w_state_nxt            = S_WB;
            w_ctrl_nxt.wr_data_sel = 1'b1;
            w_ctrl_nxt.rf_wr_enb   = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        w_ctrl_nxt.r0_sel = r_instr[11:10];
        w_ctrl_nxt.r1_sel = r_instr[9:8];
        if (r_wait_cnt == 3'd1) begin
          w_state_nxt            = S_WB;
          w_ctrl_nxt.wr_data_sel = 1'b1;
          w_ctrl_nxt.rf_wr_enb   = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 3'd1;
        end
      end
      S_WB: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Ready is registered so it stays low while reset is held and rises one edge after release.
    w_rdy_nxt = (w_state_nxt == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_instr    <= 16'h0000;
      r_wait_cnt <= 3'd0;
      r_rdy      <= 1'b0;
      r_ctrl     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_instr    <= w_instr_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_rdy      <= w_rdy_nxt;
      r_ctrl     <= w_ctrl_nxt;
    end
  end

  assign bus.instr_rdy_o       = r_rdy;
  assign bus.illegal_o         = r_ctrl.illegal;
  assign bus.data_mem_rd_enb_o = r_ctrl.rd_enb;
  assign bus.data_mem_wr_enb_o = r_ctrl.wr_enb;
  assign bus.wr_data_sel_o     = r_ctrl.wr_data_sel;
  assign bus.rf_wr_enb_o       = r_ctrl.rf_wr_enb;
  assign bus.r0_const_sel_o    = r_ctrl.r0_const_sel;
  assign bus.r1_const_sel_o    = r_ctrl.r1_const_sel;
  assign bus.cf_sel_o          = r_ctrl.cf_sel;
  assign bus.cmp_flag_sel_o    = r_ctrl.cmp_flag_sel;
  assign bus.alu_sel_0_o       = r_ctrl.alu_sel_0;
  assign bus.alu_sel_1_o       = r_ctrl.alu_sel_1;
  assign bus.inv_sel_o         = r_ctrl.inv_sel;
  assign bus.shftr_sel_o       = r_ctrl.shftr_sel;
  assign bus.shftl_sel_o       = r_ctrl.shftl_sel;
  assign bus.r0_sel_o          = r_ctrl.r0_sel;
  assign bus.r1_sel_o          = r_ctrl.r1_sel;

`ifdef EU_SEQ_RETIRE_CNT_EN
  logic        w_retire;
  logic [15:0] r_retired_cnt;

  // An instruction retires on its final cycle: EXEC for everything except LD, WB for LD.
  assign w_retire = ((r_state == S_EXEC) && (r_instr[15:12] != OP_LD)) || (r_state == S_WB);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retired_cnt <= 16'h0000;
    end else if (w_retire) begin
      r_retired_cnt <= r_retired_cnt + 16'd1;
    end
  end

  assign bus.retired_cnt_o = r_retired_cnt;
`else
  assign bus.retired_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_eu_seq_ctrl.sv
// tb/tb_eu_seq_ctrl.sv - self-checking bench for eu_seq_ctrl with MEM_RD_LAT=3
module tb_eu_seq_ctrl;

  localparam int LAT = 3;

  typedef struct packed {
    logic       rdy;
    logic       illegal;
    logic       rd;
    logic       wr;
    logic       wds;
    logic       rfw;
    logic       r0c;
    logic       r1c;
    logic       cf;
    logic       cmp;
    logic [1:0] alu0;
    logic       alu1;
    logic       inv;
    logic       shr;
    logic       shl;
    logic [1:0] r0;
    logic [1:0] r1;
  } exp_t;

  logic clk;
  logic rst;
  logic armed;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  bit   last_q[$];
  logic [15:0] model_cnt;

  eu_seq_ctrl_if bus();

  eu_seq_ctrl #(.MEM_RD_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  function automatic exp_t actual();
    exp_t a;
    a.rdy = bus.instr_rdy_o;        a.illegal = bus.illegal_o;
    a.rd  = bus.data_mem_rd_enb_o;  a.wr      = bus.data_mem_wr_enb_o;
    a.wds = bus.wr_data_sel_o;      a.rfw     = bus.rf_wr_enb_o;
    a.r0c = bus.r0_const_sel_o;     a.r1c     = bus.r1_const_sel_o;
    a.cf  = bus.cf_sel_o;           a.cmp     = bus.cmp_flag_sel_o;
    a.alu0 = bus.alu_sel_0_o;       a.alu1    = bus.alu_sel_1_o;
    a.inv = bus.inv_sel_o;          a.shr     = bus.shftr_sel_o;
    a.shl = bus.shftl_sel_o;        a.r0      = bus.r0_sel_o;
    a.r1  = bus.r1_sel_o;
    return a;
  endfunction

  // Per-instruction cycle schedule from the opcode table: EXEC, then for LD the wait cycles and WB.
  task automatic push_schedule(input logic [15:0] ins);
    exp_t e, h;
    int   op;
    op = int'(ins[15:12]);
    e = '0;
    e.r0 = ins[11:10];
    e.r1 = ins[9:8];
    h = e;
    case (op)
      1, 2, 3, 4: begin e.alu0 = 2'(op - 1); e.rfw = 1'b1; end
      5: begin e.alu1 = 1'b1; e.inv = 1'b1; e.rfw = 1'b1; end
      6: begin e.alu1 = 1'b1; e.shr = 1'b1; e.rfw = 1'b1; end
      7: begin e.alu1 = 1'b1; e.shl = 1'b1; e.rfw = 1'b1; end
      8: begin e.r0c = 1'b1; e.rfw = 1'b1; end
      9: e.rd = 1'b1;
      10: e.wr = 1'b1;
      11: e.cmp = 1'b1;
      12: begin e.cmp = 1'b1; e.cf = 1'b1; end
      13, 14, 15: e.illegal = 1'b1;
      default: ;
    endcase
    exp_q.push_back(e);
    if (op == 9) begin
      last_q.push_back(1'b0);
      for (int k = 0; k < LAT - 1; k++) begin
        exp_q.push_back(h);
        last_q.push_back(1'b0);
      end
      h.wds = 1'b1;
      h.rfw = 1'b1;
      exp_q.push_back(h);
      last_q.push_back(1'b1);
    end else begin
      last_q.push_back(1'b1);
    end
  endtask

  initial begin
    exp_t e, a;
    bit   last;
    logic [15:0] exp_cnt;
    @(posedge clk);
    forever begin
      @(negedge clk);
      last = 1'b0;
      if (!rst) begin
        exp_q.delete();
        last_q.delete();
        model_cnt = 16'h0000;
        e = '0;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        last = last_q.pop_front();
      end else begin
        e = '0;
        e.rdy = armed;
      end
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t actual=%h expected=%h", $time, a, e);
      end
`ifdef EU_SEQ_RETIRE_CNT_EN
      exp_cnt = model_cnt;
`else
      exp_cnt = 16'h0000;
`endif
      checks++;
      if (bus.retired_cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL retired_cnt t=%0t actual=%h expected=%h", $time, bus.retired_cnt_o, exp_cnt);
      end
      if (last) model_cnt = model_cnt + 16'd1;
      if (rst && e.rdy && bus.instr_vld_i) push_schedule(bus.instr_i);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Presents ins until accepted; returns at the start of its EXEC cycle (posedge + 1).
  task automatic issue(input logic [15:0] ins);
    int n;
    n = 0;
    bus.instr_vld_i = 1'b1;
    bus.instr_i     = ins;
    @(negedge clk);
    while (!bus.instr_rdy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_rdy_o) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout instr=%h actual=rdy_low required=rdy_high", ins);
    end
    @(posedge clk);
    #1;
    bus.instr_vld_i = 1'b0;
    bus.instr_i     = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    bit  wb_seen, rfw_seen;
    logic wb_rfw;
    logic [1:0] wb_r0;
    checks = 0;
    errors = 0;
    model_cnt = 16'h0000;
    rst = 1'b0;
    bus.instr_vld_i = 1'b0;
    bus.instr_i     = 16'h0000;
    repeat (3) @(posedge clk);
    #3;
    check("reset_rdy", 16'(bus.instr_rdy_o), 16'h0);
    rst = 1'b1;
    step();
    check("rdy_after_release", 16'(bus.instr_rdy_o), 16'h1);

    issue(16'h1600);
    check("add_alu_sel_0", 16'(bus.alu_sel_0_o), 16'h0);
    check("add_r0_sel", 16'(bus.r0_sel_o), 16'h1);
    check("add_r1_sel", 16'(bus.r1_sel_o), 16'h2);
    check("add_rf_wr", 16'(bus.rf_wr_enb_o), 16'h1);
    step();
    check("add_rdy_back", 16'(bus.instr_rdy_o), 16'h1);

    issue(16'h9C10);
    check("ld_rd_enb", 16'(bus.data_mem_rd_enb_o), 16'h1);
    n = 0;
    wb_seen = 1'b0;
    wb_rfw = 1'b0;
    wb_r0 = 2'd0;
    @(negedge clk);
    while (!bus.instr_rdy_o && n < 20) begin
      if (bus.wr_data_sel_o) begin
        wb_seen = 1'b1;
        wb_rfw  = bus.rf_wr_enb_o;
        wb_r0   = bus.r0_sel_o;
      end
      n++;
      @(negedge clk);
    end
    check("ld_rdy_low_cycles", 16'(n), 16'd4);
    check("ld_wb_seen", 16'(wb_seen), 16'h1);
    check("ld_wb_rf_wr", 16'(wb_rfw), 16'h1);
    check("ld_wb_r0_sel", 16'(wb_r0), 16'h3);
    step();

    issue(16'hA000);
    check("st_wr_enb", 16'(bus.data_mem_wr_enb_o), 16'h1);
    issue(16'hC400);
    check("cmplt_cmp_flag", 16'(bus.cmp_flag_sel_o), 16'h1);
    check("cmplt_cf_sel", 16'(bus.cf_sel_o), 16'h1);
    check("cmplt_wr_enb_gone", 16'(bus.data_mem_wr_enb_o), 16'h0);
    step();

    issue(16'hE000);
    check("ill_pulse", 16'(bus.illegal_o), 16'h1);
    check("ill_no_enb", 16'({bus.rf_wr_enb_o, bus.data_mem_rd_enb_o, bus.data_mem_wr_enb_o}), 16'h0);
    step();
    check("ill_pulse_end", 16'(bus.illegal_o), 16'h0);

    for (int op = 0; op < 16; op++) begin
      issue({4'(op), 2'(op), 2'(3 - (op % 4)), 8'hA5});
    end
    repeat (LAT + 2) step();

    issue(16'h9400);
    step();
    check("ldwait_r0_hold", 16'(bus.r0_sel_o), 16'h1);
    rst = 1'b0;
    #1;
    check("reset_all_zero", 16'(actual() != '0), 16'h0);
    rfw_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rf_wr_enb_o) rfw_seen = 1'b1;
    end
    check("abort_no_rf_wr", 16'(rfw_seen), 16'h0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rdy_low_first_cycle", 16'(bus.instr_rdy_o), 16'h0);
    step();
    check("rdy_high_after_edge", 16'(bus.instr_rdy_o), 16'h1);

    issue(16'h0000);
    issue(16'h0000);
    issue(16'h0000);
    step();
    step();
`ifdef EU_SEQ_RETIRE_CNT_EN
    check("retired_after_3_nops", bus.retired_cnt_o, 16'd3);
`else
    check("retired_tied_zero", bus.retired_cnt_o, 16'h0000);
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
